// File: rtl/pipe_cla_adder.sv
// ============================================================================
//  Module   : pipe_cla_adder
//  Purpose  : Pipelined carry-lookahead adder/subtractor. The operands are cut
//             into 4-bit lookahead groups and one group is resolved per stage,
//             so the carry chain never spans more than one group per cycle.
//             Results leave through a valid/ready handshake at one per cycle.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             in_valid/in_ready  - operand handshake
//             a, b, ci, sub      - operands, carry-in, subtract select
//             out_valid/out_ready- result handshake
//             s, co, g, p, ovf   - sum, carry-out, word generate/propagate,
//                                  signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_cla_adder #(
    parameter int WIDTH = 16    // multiple of 4, at least 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             g,
    output logic             p,
    output logic             ovf
);

    localparam int GROUPS = WIDTH / 4;

    // Result of one 4-bit lookahead group.
    typedef struct packed {
        logic [3:0] sum;
        logic       c3;     // carry into the group's top bit (for overflow)
        logic       c4;     // carry out of the group
        logic       gg;     // group generate
        logic       gp;     // group propagate
    } cla4_t;

    function automatic cla4_t cla4(input logic [3:0] i_x,
                                   input logic [3:0] i_y,
                                   input logic       i_c0);
        logic [3:0] w_gb;
        logic [3:0] w_pb;
        logic       w_c1;
        logic       w_c2;
        logic       w_c3;
        cla4_t      w_r;
        w_gb = i_x & i_y;
        w_pb = i_x ^ i_y;
        w_c1 = w_gb[0] | (w_pb[0] & i_c0);
        w_c2 = w_gb[1] | (w_pb[1] & w_gb[0]) | (w_pb[1] & w_pb[0] & i_c0);
        w_c3 = w_gb[2] | (w_pb[2] & w_gb[1]) | (w_pb[2] & w_pb[1] & w_gb[0])
             | (w_pb[2] & w_pb[1] & w_pb[0] & i_c0);
        w_r.gg  = w_gb[3] | (w_pb[3] & w_gb[2]) | (w_pb[3] & w_pb[2] & w_gb[1])
                | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0]);
        w_r.gp  = &w_pb;
        w_r.c4  = w_r.gg | (w_r.gp & i_c0);
        w_r.c3  = w_c3;
        w_r.sum = w_pb ^ {w_c3, w_c2, w_c1, i_c0};
        return w_r;
    endfunction

    // Stage registers. Stage k holds the operands (b already inverted for
    // subtract), the carry into group k, the low sum groups resolved so far,
    // and the running word generate/propagate of groups below k.
    logic [WIDTH-1:0]  r_a [GROUPS];
    logic [WIDTH-1:0]  r_b [GROUPS];
    logic [WIDTH-1:0]  r_s [GROUPS];
    logic [GROUPS-1:0] r_c;
    logic [GROUPS-1:0] r_gg;
    logic [GROUPS-1:0] r_gp;
    logic [GROUPS-1:0] r_v;

    logic [WIDTH-1:0]  r_s_out;
    logic              r_co;
    logic              r_g;
    logic              r_p;
    logic              r_ovf;
    logic              r_out_valid;

    cla4_t             w_cla    [GROUPS];
    logic [WIDTH-1:0]  w_s_nxt  [GROUPS];
    logic [GROUPS-1:0] w_gg_nxt;
    logic [GROUPS-1:0] w_gp_nxt;
    logic              w_en;

    // The whole pipeline moves together; a held result freezes every stage.
    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en & ~rst;

    always_comb begin
        w_gg_nxt = '0;
        w_gp_nxt = '0;
        for (int k = 0; k < GROUPS; k++) begin
            w_cla[k]            = cla4(r_a[k][4*k +: 4], r_b[k][4*k +: 4], r_c[k]);
            w_s_nxt[k]          = r_s[k];
            w_s_nxt[k][4*k +: 4] = w_cla[k].sum;
            w_gg_nxt[k]         = w_cla[k].gg | (w_cla[k].gp & r_gg[k]);
            w_gp_nxt[k]         = w_cla[k].gp & r_gp[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_out_valid <= 1'b0;
            r_s_out     <= '0;
            r_co        <= 1'b0;
            r_g         <= 1'b0;
            r_p         <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            // in_ready equals w_en here, so in_valid alone marks an accept.
            r_v[0]  <= in_valid;
            r_a[0]  <= a;
            r_b[0]  <= b ^ {WIDTH{sub}};
            r_c[0]  <= sub | ci;
            r_s[0]  <= '0;
            // Empty prefix: no generate, full propagate.
            r_gg[0] <= 1'b0;
            r_gp[0] <= 1'b1;
            for (int k = 1; k < GROUPS; k++) begin
                r_v[k]  <= r_v[k-1];
                r_a[k]  <= r_a[k-1];
                r_b[k]  <= r_b[k-1];
                r_c[k]  <= w_cla[k-1].c4;
                r_s[k]  <= w_s_nxt[k-1];
                r_gg[k] <= w_gg_nxt[k-1];
                r_gp[k] <= w_gp_nxt[k-1];
            end
            r_out_valid <= r_v[GROUPS-1];
            r_s_out     <= w_s_nxt[GROUPS-1];
            r_co        <= w_cla[GROUPS-1].c4;
            r_g         <= w_gg_nxt[GROUPS-1];
            r_p         <= w_gp_nxt[GROUPS-1];
            r_ovf       <= w_cla[GROUPS-1].c3 ^ w_cla[GROUPS-1].c4;
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s_out;
    assign co        = r_co;
    assign g         = r_g;
    assign p         = r_p;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
// ============================================================================
//  Module   : tb_pipe_cla_adder
//  Purpose  : Self-checking bench for pipe_cla_adder at WIDTH 16, 4 and 32.
//             Expected results are queued at accept and compared every cycle
//             the matching DUT presents out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_cla_adder;

    typedef struct {
        int          d;
        logic [31:0] s;
        logic [3:0]  f;     // {co, g, p, ovf}
        int          tag;
        bit          seen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] da   [3];
    logic [31:0] db   [3];
    logic        dv   [3];
    logic        dci  [3];
    logic        dsub [3];
    logic        drdy [3];

    logic        ir0, ov0, co0, g0, p0, ovf0;
    logic [15:0] s0;
    logic        ir1, ov1, co1, g1, p1, ovf1;
    logic [3:0]  s1;
    logic        ir2, ov2, co2, g2, p2, ovf2;
    logic [31:0] s2;

    exp_t        sb [$];
    int          ecount [3];
    bit          acc [3];
    bit          use_ovr;
    logic [31:0] ovr_s;
    logic [3:0]  ovr_f;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(dv[0]), .in_ready(ir0),
        .a(da[0][15:0]), .b(db[0][15:0]), .ci(dci[0]), .sub(dsub[0]),
        .out_valid(ov0), .out_ready(drdy[0]),
        .s(s0), .co(co0), .g(g0), .p(p0), .ovf(ovf0));

    pipe_cla_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(dv[1]), .in_ready(ir1),
        .a(da[1][3:0]), .b(db[1][3:0]), .ci(dci[1]), .sub(dsub[1]),
        .out_valid(ov1), .out_ready(drdy[1]),
        .s(s1), .co(co1), .g(g1), .p(p1), .ovf(ovf1));

    pipe_cla_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(dv[2]), .in_ready(ir2),
        .a(da[2]), .b(db[2]), .ci(dci[2]), .sub(dsub[2]),
        .out_valid(ov2), .out_ready(drdy[2]),
        .s(s2), .co(co2), .g(g2), .p(p2), .ovf(ovf2));

    function automatic int wid(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    function automatic void get_obs(input int d, output logic o_ir, output logic o_ov,
                                    output logic [31:0] o_s, output logic [3:0] o_f);
        case (d)
            0: begin o_ir = ir0; o_ov = ov0; o_s = {16'd0, s0}; o_f = {co0, g0, p0, ovf0}; end
            1: begin o_ir = ir1; o_ov = ov1; o_s = {28'd0, s1}; o_f = {co1, g1, p1, ovf1}; end
            default: begin o_ir = ir2; o_ov = ov2; o_s = s2; o_f = {co2, g2, p2, ovf2}; end
        endcase
    endfunction

    // Reference: plain wide arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input int d, input int w, input logic [31:0] x,
                                   input logic [31:0] y, input logic c, input logic sb_i);
        logic [63:0] mask, ae, be, part, sum;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        ae   = {32'd0, x} & mask;
        be   = {32'd0, (sb_i ? ~y : y)} & mask;
        part = ae + be;
        sum  = part + {63'd0, (sb_i | c)};
        e.d    = d;
        e.s    = sum[31:0] & mask[31:0];
        e.f    = {sum[w], part[w], ((ae ^ be) == mask),
                  ((ae[w-1] == be[w-1]) && (sum[w-1] != ae[w-1]))};
        e.tag  = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    function automatic int head(input int d);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].d == d) return i;
        return -1;
    endfunction

    // One clock: sample at the falling edge, account accepts/pops, then
    // return 1 time unit after the rising edge for the next drive.
    task automatic tick();
        logic        ir, ov;
        logic [31:0] os;
        logic [3:0]  of;
        int          h;
        bit          en;
        exp_t        e;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            get_obs(d, ir, ov, os, of);
            acc[d] = 1'b0;
            if (rst) begin
                n_tests++;
                assert (ir === 1'b0) else begin
                    n_fail++; $error("FAIL in_ready_rst d%0d: observed %b expected 0", d, ir);
                end
            end else begin
                en = !ov || drdy[d];
                n_tests++;
                assert (ir === en) else begin
                    n_fail++; $error("FAIL in_ready d%0d: observed %b expected %b", d, ir, en);
                end
                if (ov) begin
                    h = head(d);
                    n_tests++;
                    assert ((h >= 0) === 1'b1) else begin
                        n_fail++; $error("FAIL spurious_out d%0d: observed out_valid=1 expected 0", d);
                    end
                    if (h >= 0) begin
                        e = sb[h];
                        n_tests++;
                        assert ({os, of} === {e.s, e.f}) else begin
                            n_fail++;
                            $error("FAIL result d%0d: observed s=%h f=%b expected s=%h f=%b",
                                   d, os, of, e.s, e.f);
                        end
                        if (!e.seen) begin
                            n_tests++;
                            assert ((ecount[d] - e.tag) === wid(d) / 4) else begin
                                n_fail++;
                                $error("FAIL latency d%0d: observed %0d expected %0d",
                                       d, ecount[d] - e.tag, wid(d) / 4);
                            end
                            e.seen = 1'b1;
                            sb[h]  = e;
                        end
                        if (drdy[d]) sb.delete(h);
                    end
                end
                if (dv[d] && ir) begin
                    acc[d] = 1'b1;
                    if (d == 0 && use_ovr) begin
                        e.d = 0; e.s = ovr_s; e.f = ovr_f; e.seen = 1'b0;
                    end else begin
                        e = model(d, wid(d), da[d], db[d], dci[d], dsub[d]);
                    end
                    e.tag = ecount[d] + 1;
                    sb.push_back(e);
                end
                if (en) ecount[d]++;
            end
        end
        if (rst) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d, input int maxc);
        int c;
        c = 0;
        while (head(d) >= 0 && c < maxc) begin
            tick();
            c++;
        end
        n_tests++;
        assert ((head(d) < 0) === 1'b1) else begin
            n_fail++; $error("FAIL drain_timeout d%0d: observed pending expected none", d);
        end
    endtask

    task automatic send0(input logic [31:0] x, input logic [31:0] y, input logic c,
                         input logic sb_i, input logic [31:0] es, input logic [3:0] ef);
        da[0] = x; db[0] = y; dci[0] = c; dsub[0] = sb_i; dv[0] = 1'b1;
        use_ovr = 1'b1; ovr_s = es; ovr_f = ef;
        tick();
        n_tests++;
        assert (acc[0] === 1'b1) else begin
            n_fail++; $error("FAIL accept d0: observed %b expected 1", acc[0]);
        end
        dv[0] = 1'b0; use_ovr = 1'b0;
        drain(0, 50);
    endtask

    task automatic check_zero_out();
        logic        ir, ov;
        logic [31:0] os;
        logic [3:0]  of;
        for (int d = 0; d < 3; d++) begin
            get_obs(d, ir, ov, os, of);
            n_tests++;
            assert ({ov, os, of} === 37'd0) else begin
                n_fail++;
                $error("FAIL reset_out d%0d: observed v=%b s=%h f=%b expected all 0", d, ov, os, of);
            end
        end
    endtask

    initial begin
        int sent;
        int c;
        int sent_r [3];
        for (int d = 0; d < 3; d++) begin
            da[d] = '0; db[d] = '0; dv[d] = 1'b0; dci[d] = 1'b0;
            dsub[d] = 1'b0; drdy[d] = 1'b1; ecount[d] = 0; acc[d] = 1'b0;
        end
        use_ovr = 1'b0; ovr_s = '0; ovr_f = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_zero_out();
        rst = 1'b0;

        // Directed vectors, WIDTH=16
        send0(32'h0001, 32'h0003, 1'b1, 1'b0, 32'h0005, 4'b0000);
        send0(32'h5555, 32'hAAAA, 1'b1, 1'b0, 32'h0000, 4'b1010);
        send0(32'h5555, 32'hAAAA, 1'b0, 1'b0, 32'hFFFF, 4'b0010);
        send0(32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 32'hFFFF, 4'b1100);
        send0(32'h7FFF, 32'hFFFF, 1'b1, 1'b1, 32'h8000, 4'b0001);
        send0(32'h0005, 32'h0003, 1'b0, 1'b1, 32'h0002, 4'b1100);

        // Back-pressure: 8-beat stream with out_ready low for 5 cycles
        sent = 0; c = 0;
        da[0] = $urandom; db[0] = $urandom; dci[0] = 1'($urandom); dsub[0] = 1'($urandom);
        dv[0] = 1'b1;
        while (sent < 8 && c < 100) begin
            drdy[0] = !(c >= 3 && c < 8);
            tick();
            if (acc[0]) begin
                sent++;
                da[0] = $urandom; db[0] = $urandom; dci[0] = 1'($urandom); dsub[0] = 1'($urandom);
            end
            c++;
        end
        dv[0] = 1'b0; drdy[0] = 1'b1;
        n_tests++;
        assert (sent === 8) else begin
            n_fail++; $error("FAIL stream_count: observed %0d expected 8", sent);
        end
        drain(0, 50);

        // Reset mid-flight: three beats in flight are discarded
        for (int i = 0; i < 3; i++) begin
            da[0] = 32'h1000 + i; db[0] = 32'h0100; dci[0] = 1'b0; dsub[0] = 1'b0; dv[0] = 1'b1;
            tick();
        end
        dv[0] = 1'b0;
        rst = 1'b1;
        tick();
        check_zero_out();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        send0(32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 4'b0000);

        // Random traffic on WIDTH=4 and WIDTH=32 with random valid/ready
        sent_r[1] = 0; sent_r[2] = 0; c = 0;
        while ((sent_r[1] < 1000 || sent_r[2] < 1000) && c < 20000) begin
            for (int d = 1; d < 3; d++) begin
                dv[d]   = (sent_r[d] < 1000) && ($urandom_range(3) != 0);
                drdy[d] = ($urandom_range(3) != 0);
                da[d]   = $urandom; db[d] = $urandom;
                dci[d]  = 1'($urandom); dsub[d] = 1'($urandom);
            end
            tick();
            for (int d = 1; d < 3; d++) if (acc[d]) sent_r[d]++;
            c++;
        end
        dv[1] = 1'b0; dv[2] = 1'b0; drdy[1] = 1'b1; drdy[2] = 1'b1;
        n_tests++;
        assert ((sent_r[1] + sent_r[2]) === 2000) else begin
            n_fail++; $error("FAIL random_count: observed %0d expected 2000", sent_r[1] + sent_r[2]);
        end
        drain(1, 50);
        drain(2, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
